hwmod_rst_ctrl: RTL and testbench

Responder on the violation side of the hardware monitor. Consumes the monitor's `reset` request and `exec` flag, sequences a bounded system reset request (`puc_req`) toward the openMSP430 reset generator, and records the violation count, cause PC and exec status in three memory-mapped registers on the peripheral bus. It sits between `hwmod` and the core's reset/peripheral infrastructure. Its `puc_req` becomes the `puc` the monitor observes.

---
 rtl/hwmod_rst_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hwmod_rst_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwmod_rst_ctrl.sv
// hwmod_rst_ctrl: violation responder for the hardware monitor.
// Sequences a bounded reset request (puc_req) on each violation and exposes
// STATUS / VCNT / PCLOG as peripheral registers at BASE_ADDR .. BASE_ADDR+2.
// Optional feature macro: HWMOD_PC_LOG_EN (PCLOG capture of pc on violation).
module hwmod_rst_ctrl #(
    parameter logic [13:0] BASE_ADDR    = 14'h00C8,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        viol_req,
    input  logic        exec,
    input  logic [15:0] pc,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    output logic [15:0] per_dout,
    output logic        puc_req,
    output logic        rst_active
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    localparam logic [13:0] ADDR_STATUS = BASE_ADDR;
    localparam logic [13:0] ADDR_VCNT   = BASE_ADDR + 14'd1;
    localparam logic [13:0] ADDR_PCLOG  = BASE_ADDR + 14'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GUARD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_puc_req;
    logic             r_rst_active;
    logic             r_exec;
    logic             r_sticky;
    logic [7:0]       r_vcnt;

    logic             w_viol_new;
    logic             w_rd;
    logic             w_wr;
    logic             w_wr_status;
    logic             w_wr_vcnt;
    logic [15:0]      w_pclog;
    logic             w_unused_din;

    // A violation counts as a new event only when it arrives in IDLE
    assign w_viol_new  = (r_state == ST_IDLE) && viol_req;
    assign w_rd        = per_en && (per_we == 2'b00);
    assign w_wr        = per_en && (per_we != 2'b00);
    assign w_wr_status = w_wr && (per_addr == ADDR_STATUS);
    assign w_wr_vcnt   = w_wr && (per_addr == ADDR_VCNT);

    assign w_unused_din = ^{per_din[15:2], per_din[0]};

    assign puc_req    = r_puc_req;
    assign rst_active = r_rst_active;

    // Reset sequencing FSM with registered puc_req / rst_active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_puc_req    <= 1'b0;
            r_rst_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (viol_req) begin
                        r_state      <= ST_ASSERT;
                        r_cnt        <= RST_LOAD;
                        r_puc_req    <= 1'b1;
                        r_rst_active <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // cnt parks at 0 while viol_req stays high, stretching puc_req
                    if (r_cnt == '0) begin
                        if (!viol_req) begin
                            r_state   <= ST_GUARD;
                            r_cnt     <= GUARD_LOAD;
                            r_puc_req <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (viol_req) begin
                        r_state   <= ST_ASSERT;
                        r_cnt     <= RST_LOAD;
                        r_puc_req <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state      <= ST_IDLE;
                        r_rst_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_puc_req    <= 1'b0;
                    r_rst_active <= 1'b0;
                end
            endcase
        end
    end

    // STATUS bits: registered exec and sticky flag (set beats write-1-clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exec   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_exec <= exec;
            if (w_viol_new) begin
                r_sticky <= 1'b1;
            end else if (w_wr_status && per_din[1]) begin
                r_sticky <= 1'b0;
            end
        end
    end

    // Saturating violation counter; a clear coinciding with an increment yields 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vcnt <= '0;
        end else if (w_viol_new) begin
            if (w_wr_vcnt) begin
                r_vcnt <= 8'd1;
            end else if (r_vcnt != '1) begin
                r_vcnt <= r_vcnt + 8'd1;
            end
        end else if (w_wr_vcnt) begin
            r_vcnt <= '0;
        end
    end

`ifdef HWMOD_PC_LOG_EN
    logic [15:0] r_pclog;

    // Capture the PC of each new violation event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pclog <= '0;
        end else if (w_viol_new) begin
            r_pclog <= pc;
        end
    end

    assign w_pclog = r_pclog;
`else
    logic w_unused_pc;

    assign w_unused_pc = ^pc;
    assign w_pclog     = '0;
`endif

    // Read mux: data only on a selected read, 0 otherwise (including writes)
    always_comb begin
        per_dout = '0;
        if (w_rd) begin
            case (per_addr)
                ADDR_STATUS: per_dout = {13'd0, r_rst_active, r_sticky, r_exec};
                ADDR_VCNT:   per_dout = {8'd0, r_vcnt};
                ADDR_PCLOG:  per_dout = w_pclog;
                default:     per_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hwmod_rst_ctrl.sv
// Self-checking bench for hwmod_rst_ctrl: table vectors, directed corner
// sequences and randomized traffic against an event-level reference model.
module tb_hwmod_rst_ctrl;

    localparam int          RST  = 4;
    localparam int          GRD  = 8;
    localparam logic [13:0] BASE = 14'h00C8;
    localparam logic [13:0] A_ST = BASE;
    localparam logic [13:0] A_VC = BASE + 14'd1;
    localparam logic [13:0] A_PC = BASE + 14'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        viol_req;
    logic        exec;
    logic [15:0] pc;
    logic        per_en;
    logic [1:0]  per_we;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic [15:0] per_dout;
    logic        puc_req;
    logic        rst_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: event timing expressed as edge timestamps
    bit          m_busy;
    bit          m_puc;
    int          m_start;
    int          m_gend;
    bit          m_sticky;
    bit          m_exec;
    int          m_vcnt;
    logic [15:0] m_pclog;

    hwmod_rst_ctrl #(
        .BASE_ADDR   (BASE),
        .RST_CYCLES  (RST),
        .GUARD_CYCLES(GRD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .viol_req  (viol_req),
        .exec      (exec),
        .pc        (pc),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_dout  (per_dout),
        .puc_req   (puc_req),
        .rst_active(rst_active)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_puc    = 0;
        m_start  = 0;
        m_gend   = 0;
        m_sticky = 0;
        m_exec   = 0;
        m_vcnt   = 0;
        m_pclog  = '0;
    endtask

    // Apply the rules to the inputs sampled on edge number cyc
    task automatic model_edge();
        bit newev;
        bit wr;
        newev = !m_busy && viol_req;
        wr    = per_en && (per_we != 2'b00);
        if (!m_busy) begin
            if (viol_req) begin
                m_busy  = 1;
                m_puc   = 1;
                m_start = cyc;
            end
        end else if (m_puc) begin
            if (cyc >= m_start + RST && !viol_req) begin
                m_puc  = 0;
                m_gend = cyc + GRD;
            end
        end else begin
            if (viol_req) begin
                m_puc   = 1;
                m_start = cyc;
            end else if (cyc >= m_gend) begin
                m_busy = 0;
            end
        end
        if (newev) m_sticky = 1;
        else if (wr && per_addr == A_ST && per_din[1]) m_sticky = 0;
        if (wr && per_addr == A_VC) m_vcnt = newev ? 1 : 0;
        else if (newev && m_vcnt < 255) m_vcnt++;
`ifdef HWMOD_PC_LOG_EN
        if (newev) m_pclog = pc;
`endif
        m_exec = exec;
    endtask

    function automatic logic [15:0] exp_dout();
        if (!(per_en && per_we == 2'b00)) return 16'h0000;
        if (per_addr == A_ST) return {13'd0, m_busy, m_sticky, m_exec};
        if (per_addr == A_VC) return {8'd0, 8'(m_vcnt)};
        if (per_addr == A_PC) return m_pclog;
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        viol_req = 0;
        per_en   = 0;
        per_we   = 2'b00;
        per_addr = '0;
        per_din  = '0;
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string nm);
        per_en   = 1;
        per_we   = 2'b00;
        per_addr = a;
        #1;
        chk(nm, per_dout, exp);
        per_en = 0;
        tick();
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d);
        per_en   = 1;
        per_we   = 2'b11;
        per_addr = a;
        per_din  = d;
        tick();
        per_en = 0;
        per_we = 2'b00;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (rst_active && k < 100) begin
            tick();
            k++;
        end
        if (rst_active) chk("idle_timeout", rst_active, 0);
    endtask

    task automatic pulse();
        viol_req = 1;
        tick();
        viol_req = 0;
    endtask

    typedef struct {
        bit          en;
        logic [1:0]  we;
        logic [13:0] addr;
        logic [15:0] din;
        bit          ex;
        logic [15:0] exp_dout;
        bit          exp_puc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int pcnt;
        int acnt;
        int burst;

        tbl[0]  = '{1, 2'b00, A_ST,         16'h0000, 0, 16'h0000, 0};
        tbl[1]  = '{1, 2'b00, A_VC,         16'h0000, 0, 16'h0000, 0};
        tbl[2]  = '{1, 2'b00, A_PC,         16'h0000, 0, 16'h0000, 0};
        tbl[3]  = '{1, 2'b00, BASE + 14'd3, 16'h0000, 0, 16'h0000, 0};
        tbl[4]  = '{1, 2'b11, A_ST,         16'hFFFF, 0, 16'h0000, 0};
        tbl[5]  = '{1, 2'b00, A_ST,         16'h0000, 1, 16'h0000, 0};
        tbl[6]  = '{1, 2'b00, A_ST,         16'h0000, 0, 16'h0001, 0};
        tbl[7]  = '{1, 2'b00, A_ST,         16'h0000, 1, 16'h0000, 0};
        tbl[8]  = '{1, 2'b10, A_ST,         16'h0000, 1, 16'h0000, 0};
        tbl[9]  = '{0, 2'b00, A_ST,         16'h0000, 0, 16'h0000, 0};
        tbl[10] = '{1, 2'b00, A_ST,         16'h0000, 0, 16'h0000, 0};

        reset_n = 0;
        exec    = 0;
        pc      = '0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_puc", puc_req, 0);
        chk("reset_rst_active", rst_active, 0);
        reset_n = 1;

        // Table vectors: register access right after reset
        foreach (tbl[i]) begin
            per_en   = tbl[i].en;
            per_we   = tbl[i].we;
            per_addr = tbl[i].addr;
            per_din  = tbl[i].din;
            exec     = tbl[i].ex;
            #1;
            chk($sformatf("tbl%0d_dout", i), per_dout, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_puc", i), puc_req, tbl[i].exp_puc);
            tick();
        end
        idle_inputs();
        exec = 0;
        tick();

        // Isolated pulse: puc exactly RST cycles, rst_active RST+GRD cycles
        pc = 16'hA010;
        chk("pulse_pre_puc", puc_req, 0);
        pulse();
        chk("pulse_puc_start", puc_req, 1);
        pcnt = 0;
        acnt = 0;
        for (int k = 0; k < 40 && rst_active; k++) begin
            pcnt += int'(puc_req);
            acnt++;
            tick();
        end
        chk("pulse_puc_cycles", pcnt, RST);
        chk("pulse_rst_active_cycles", acnt, RST + GRD);
        rd(A_ST, 16'h0002, "pulse_status");
        rd(A_VC, 16'h0001, "pulse_vcnt");
`ifdef HWMOD_PC_LOG_EN
        rd(A_PC, 16'hA010, "pulse_pclog");
`else
        rd(A_PC, 16'h0000, "pulse_pclog");
`endif

        // Held violation stretches puc; re-entry from GUARD is not a new event
        wr(A_VC, 16'h0000);
        viol_req = 1;
        pcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            pcnt += int'(puc_req);
        end
        viol_req = 0;
        tick();
        chk("hold_puc_cycles", pcnt, 20);
        chk("hold_puc_drop", puc_req, 0);
        tick();
        tick();
        pulse();
        chk("guard_reentry_puc", puc_req, 1);
        chk("guard_reentry_active", rst_active, 1);
        wait_idle();
        rd(A_VC, 16'h0001, "guard_reentry_vcnt");

        // Saturation, then clear coincident with a new event
        for (int i = 0; i < 300; i++) begin
            pulse();
            wait_idle();
        end
        rd(A_VC, 16'h00FF, "vcnt_saturate");
        per_en   = 1;
        per_we   = 2'b11;
        per_addr = A_VC;
        per_din  = 16'h0000;
        viol_req = 1;
        tick();
        idle_inputs();
        wait_idle();
        rd(A_VC, 16'h0001, "vcnt_clear_vs_inc");

        // Sticky: set wins over clear on the same edge; later clear works
        wr(A_ST, 16'h0002);
        per_en   = 1;
        per_we   = 2'b11;
        per_addr = A_ST;
        per_din  = 16'h0002;
        viol_req = 1;
        tick();
        idle_inputs();
        wait_idle();
        rd(A_ST, 16'h0002, "sticky_set_wins");
        wr(A_ST, 16'h0002);
        rd(A_ST, 16'h0000, "sticky_cleared");

        // Asynchronous reset in the middle of ASSERT
        pulse();
        tick();
        chk("mid_assert_puc", puc_req, 1);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("async_puc_drop", puc_req, 0);
        chk("async_active_drop", rst_active, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        rd(A_ST, 16'h0000, "post_reset_status");
        rd(A_VC, 16'h0000, "post_reset_vcnt");
        rd(A_PC, 16'h0000, "post_reset_pclog");
        exec = 1;
        tick();
        exec = 0;
        rd(A_ST, 16'h0001, "post_reset_exec");

        // Randomized traffic against the reference model
        burst = 0;
        for (int n = 0; n < 2000; n++) begin
            if (burst > 0) begin
                viol_req = 1;
                burst--;
            end else if ($urandom_range(0, 15) == 0) begin
                viol_req = 1;
                burst = $urandom_range(0, 5);
            end else begin
                viol_req = 0;
            end
            exec   = 1'($urandom);
            pc     = 16'($urandom);
            per_en = 1'($urandom);
            per_we = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            if ($urandom_range(0, 7) == 0) per_addr = 14'($urandom);
            else per_addr = A_ST + 14'($urandom_range(0, 3));
            if (per_addr == A_VC && per_we != 2'b00 && $urandom_range(0, 3) != 0) per_we = 2'b00;
            per_din = 16'($urandom);
            #1;
            chk("rand_dout", per_dout, exp_dout());
            chk("rand_puc", puc_req, m_puc);
            chk("rand_rst_active", rst_active, m_busy);
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
